instruction_fetch: RTL and testbench

- PC register and fetch stage sitting directly upstream of the branch/jump resolution logic.
- Holds the current PC and fetches instructions over a req/ack instruction-memory interface.
- Presents each fetched instruction with its PC to decode through a one-entry valid/ready buffer.
- Accepts redirects (branch taken, j/jal, jr) carrying the resolved next PC, and discards stale fetches.

---
 rtl/instruction_fetch_pkg.sv | 23 ++
 rtl/instruction_fetch.sv | 135 +++++++++++++
 tb/tb_instruction_fetch.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU front-end definitions used by the fetch stage.
//   fetch_state_e    : fetch FSM states (request, drain stale request, hold buffer)
//   INSTR_W          : instruction word width
//   PC_INC           : sequential PC increment
//   DEFAULT_RESET_PC : default reset vector
//   word_align()     : clears the two byte-offset bits of an address
package instruction_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_DRAIN = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, req/ack instruction-memory master and
// a one-entry valid/ready output buffer toward decode.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   redirect_valid, redirect_pc  : PC change ordered by branch/jump resolution
//   imem_req, imem_addr          : fetch request (held until ack), fetch address
//   imem_ack, imem_rdata         : one-cycle ack pulse with the instruction word
//   if_valid, if_ready           : output buffer handshake toward decode
//   if_pc, if_instr, if_pc_plus4 : buffered instruction, its PC and PC+4
// All outputs come straight from flops.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [31:0]        if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc_plus4
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;             // next address to fetch
    logic [31:0]        req_addr_q, req_addr_d; // address in flight
    logic               imem_req_q, imem_req_d;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [31:0]        if_pc_plus4_q, if_pc_plus4_d;

    logic [31:0]        redir_pc;
    logic [31:0]        req_addr_inc;

    assign redir_pc     = word_align(redirect_pc);
    assign req_addr_inc = req_addr_q + PC_INC;   // wraps modulo 2^32

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_pc_plus4_d = if_pc_plus4_q;

        case (state_q)
            FS_REQ: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        // Word just returned belongs to the old path: drop it
                        // and issue the new target immediately.
                        req_addr_d = redir_pc;
                    end else begin
                        // Request cannot be withdrawn; let it complete first.
                        pc_d    = redir_pc;
                        state_d = FS_DRAIN;
                    end
                end else if (imem_ack) begin
                    if_valid_d    = 1'b1;
                    if_pc_d       = req_addr_q;
                    if_instr_d    = imem_rdata;
                    if_pc_plus4_d = req_addr_inc;
                    pc_d          = req_addr_inc;
                    state_d       = FS_HOLD;
                end
            end
            FS_DRAIN: begin
                // Latest redirect wins, including one arriving with the ack.
                if (redirect_valid) begin
                    pc_d = redir_pc;
                end
                if (imem_ack) begin
                    req_addr_d = redirect_valid ? redir_pc : pc_q;
                    state_d    = FS_REQ;
                end
            end
            FS_HOLD: begin
                // Redirect beats the handshake: the buffered word is wrong-path.
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    req_addr_d = redir_pc;
                    state_d    = FS_REQ;
                end else if (if_ready) begin
                    if_valid_d = 1'b0;
                    req_addr_d = pc_q;
                    state_d    = FS_REQ;
                end
            end
            default: begin
                state_d = FS_REQ;
            end
        endcase

        imem_req_d = (state_d != FS_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FS_REQ;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            imem_req_q    <= 1'b1;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= '0;
            if_pc_plus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            imem_req_q    <= imem_req_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_plus4_q <= if_pc_plus4_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = req_addr_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc_plus4 = if_pc_plus4_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: table of sequential fetches plus hand-written
// redirect / reset sequences. Expected decode-side words are queued when the
// memory ack is driven and popped at each if_valid&&if_ready handshake.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] STALE  = 32'hDEAD_DEAD;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pc_plus4    (if_pc_plus4)
    );

    // Acking with no request outstanding would be a bench bug.
    assert property (@(posedge clk) disable iff (rst) imem_ack |-> imem_req);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        int          lat;    // idle cycles with req up before ack
        int          stall;  // cycles of if_ready=0 while holding
        logic [31:0] addr;   // expected fetch address
        logic [31:0] pc4;    // expected if_pc_plus4
    } vec_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 16 && imem_req !== 1'b1; i++) tick();
        chk("imem_req_up", 32'(imem_req), 32'd1);
    endtask

    // One complete fetch: request, memory latency, hold with back-pressure,
    // handshake checked against the scoreboard.
    task automatic do_fetch(input vec_t v);
        exp_t e;
        wait_req();
        chk("imem_addr", imem_addr, v.addr);
        repeat (v.lat) begin
            tick();
            chk("addr_stable", imem_addr, v.addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(v.addr);
        exp_q.push_back('{pc: v.addr, instr: mem_word(v.addr), pc4: v.pc4});
        tick();
        imem_ack   = 1'b0;
        imem_rdata = STALE;
        chk("if_valid_set", 32'(if_valid), 32'd1);
        chk("req_low_hold", 32'(imem_req), 32'd0);
        repeat (v.stall) begin
            tick();
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_req",   32'(imem_req), 32'd0);
            chk("stall_pc",    if_pc,    exp_q[0].pc);
            chk("stall_instr", if_instr, exp_q[0].instr);
        end
        if_ready = 1'b1;
        chk("hs_valid", 32'(if_valid), 32'd1);
        chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("if_pc",       if_pc,       e.pc);
            chk("if_instr",    if_instr,    e.instr);
            chk("if_pc_plus4", if_pc_plus4, e.pc4);
        end
        tick();
        if_ready = 1'b0;
        chk("valid_clear", 32'(if_valid), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        // Wrap from the reset vector, then streaming 0,4,8 with one long stall.
        vecs[0] = '{lat: 1, stall: 0, addr: 32'hFFFF_FFFC, pc4: 32'h0000_0000};
        vecs[1] = '{lat: 1, stall: 0, addr: 32'h0000_0000, pc4: 32'h0000_0004};
        vecs[2] = '{lat: 1, stall: 0, addr: 32'h0000_0004, pc4: 32'h0000_0008};
        vecs[3] = '{lat: 2, stall: 5, addr: 32'h0000_0008, pc4: 32'h0000_000C};
        vecs[4] = '{lat: 0, stall: 0, addr: 32'h0000_000C, pc4: 32'h0000_0010};

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = STALE; if_ready = 1'b0;
        tick(); tick();
        chk("rst_req",      32'(imem_req), 32'd1);
        chk("rst_addr",     imem_addr,     RST_PC);
        chk("rst_valid",    32'(if_valid), 32'd0);
        chk("rst_pc",       if_pc,         32'd0);
        chk("rst_instr",    if_instr,      32'd0);
        chk("rst_pc_plus4", if_pc_plus4,   32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) do_fetch(vecs[i]);

        // Redirect together with ack in REQ: word dropped, new target issued.
        wait_req();
        chk("a_addr", imem_addr, 32'h10);
        imem_ack = 1'b1; imem_rdata = STALE;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        chk("a_valid", 32'(if_valid), 32'd0);
        chk("a_req",   32'(imem_req), 32'd1);
        chk("a_next",  imem_addr,     32'h100);
        do_fetch('{lat: 1, stall: 0, addr: 32'h100, pc4: 32'h104});

        // Redirect without ack -> DRAIN, second redirect wins, ack 3 cycles on.
        wait_req();
        redirect_valid = 1'b1; redirect_pc = 32'h180;
        tick();
        chk("d_hold1", imem_addr, 32'h104);
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("d_hold2", imem_addr, 32'h104);
        tick();
        chk("d_hold3", imem_addr, 32'h104);
        chk("d_req",   32'(imem_req), 32'd1);
        imem_ack = 1'b1; imem_rdata = STALE;
        tick();
        imem_ack = 1'b0;
        chk("d_valid", 32'(if_valid), 32'd0);
        chk("d_next",  imem_addr,     32'h200);
        do_fetch('{lat: 0, stall: 0, addr: 32'h200, pc4: 32'h204});

        // Redirect in HOLD beats if_ready; target is word-aligned.
        wait_req();
        imem_ack = 1'b1; imem_rdata = mem_word(32'h204);
        tick();
        imem_ack = 1'b0;
        chk("h_valid", 32'(if_valid), 32'd1);
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h43;
        tick();
        if_ready = 1'b0; redirect_valid = 1'b0;
        chk("h_dropped", 32'(if_valid), 32'd0);
        chk("h_req",     32'(imem_req), 32'd1);
        chk("h_next",    imem_addr,     32'h40);
        do_fetch('{lat: 1, stall: 0, addr: 32'h40, pc4: 32'h44});

        // Redirect to the top word: PC+4 wraps to zero.
        wait_req();
        imem_ack = 1'b1; imem_rdata = STALE;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFD;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        do_fetch('{lat: 0, stall: 0, addr: 32'hFFFF_FFFC, pc4: 32'h0});
        do_fetch('{lat: 1, stall: 0, addr: 32'h0, pc4: 32'h4});

        // Reset while draining: back to RESET_PC, outstanding ack forgotten.
        wait_req();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        chk("r_drain_addr", imem_addr, 32'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_addr",  imem_addr,     RST_PC);
        chk("r_valid", 32'(if_valid), 32'd0);
        chk("r_req",   32'(imem_req), 32'd1);
        do_fetch('{lat: 1, stall: 0, addr: RST_PC, pc4: 32'h0});
        do_fetch('{lat: 0, stall: 2, addr: 32'h0, pc4: 32'h4});

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
